// File: rtl/ahb_sync_sram_bridge.sv
// ahb_sync_sram_bridge: zero-wait AHB-Lite subordinate for a 1-cycle synchronous SRAM with a posted one-entry write buffer
module ahb_sync_sram_bridge #(
  parameter int W_DATA = 32,
  parameter int W_ADDR = 32,
  parameter int DEPTH = 2048
)(
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     ahbls_hready,
  output logic                     ahbls_hready_resp,
  output logic                     ahbls_hresp,
  input  logic [W_ADDR-1:0]        ahbls_haddr,
  input  logic                     ahbls_hwrite,
  input  logic [1:0]               ahbls_htrans,
  input  logic [2:0]               ahbls_hsize,
  input  logic [W_DATA-1:0]        ahbls_hwdata,
  output logic [W_DATA-1:0]        ahbls_hrdata,
  output logic                     sram_cs_n,
  output logic                     sram_we_n,
  output logic [W_DATA/8-1:0]      sram_be_n,
  output logic [$clog2(DEPTH)-1:0] sram_addr,
  output logic [W_DATA-1:0]        sram_wdata,
  input  logic [W_DATA-1:0]        sram_rdata
);
  localparam int AW = $clog2(DEPTH);
  localparam int NB = W_DATA / 8;
  logic accept, rd_acc, direct_wr, capture, retire;
  logic dph_write, wbuf_valid;
  logic [AW-1:0] word, dph_addr, wbuf_addr;
  logic [NB-1:0] mask, dph_mask, wbuf_mask, merge_mask;
  logic [W_DATA-1:0] wbuf_data;
  logic unused;
  assign unused = &{1'b0, ahbls_haddr[W_ADDR-1:AW+2], ahbls_htrans[0]};
  // strobes are gated by reset so a buffered write is dropped, not retired, during reset
  assign accept    = rst_n && ahbls_hready && ahbls_htrans[1];
  assign rd_acc    = accept && !ahbls_hwrite;
  assign direct_wr = rst_n && dph_write && !rd_acc;
  assign capture   = dph_write && rd_acc;
  assign retire    = rst_n && wbuf_valid && !rd_acc;
  assign word      = ahbls_haddr[AW+1:2];
  always_comb
    mask = ahbls_hsize == 3'd0 ? 4'b0001 << ahbls_haddr[1:0] :
           ahbls_hsize == 3'd1 ? (ahbls_haddr[1] ? 4'b1100 : 4'b0011) : 4'b1111;
  assign ahbls_hready_resp = 1'b1;
  assign ahbls_hresp       = 1'b0;
  assign sram_cs_n  = !(rd_acc || direct_wr || retire);
  assign sram_we_n  = !(direct_wr || retire);
  assign sram_addr  = rd_acc ? word : direct_wr ? dph_addr : wbuf_addr;
  assign sram_be_n  = direct_wr ? ~dph_mask : retire ? ~wbuf_mask : '1;
  assign sram_wdata = direct_wr ? ahbls_hwdata : wbuf_data;
  always_comb begin
    ahbls_hrdata = sram_rdata;
    for (int i = 0; i < NB; i++)
      if (merge_mask[i]) ahbls_hrdata[8*i +: 8] = wbuf_data[8*i +: 8];
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dph_write  <= 1'b0;
      dph_addr   <= '0;
      dph_mask   <= '0;
      wbuf_valid <= 1'b0;
      wbuf_addr  <= '0;
      wbuf_mask  <= '0;
      wbuf_data  <= '0;
      merge_mask <= '0;
    end else begin
      assert (!(direct_wr && retire));
      dph_write <= accept && ahbls_hwrite;
      if (accept) begin
        dph_addr <= word;
        dph_mask <= mask;
      end
      merge_mask <= !rd_acc ? '0 :
                    (wbuf_valid && wbuf_addr == word) ? wbuf_mask :
                    (capture && dph_addr == word) ? dph_mask : '0;
      if (capture) begin
        wbuf_valid <= 1'b1;
        wbuf_addr  <= dph_addr;
        wbuf_mask  <= dph_mask;
        wbuf_data  <= ahbls_hwdata;
      end else if (retire) wbuf_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_ahb_sync_sram_bridge.sv
// tb_ahb_sync_sram_bridge: directed AHB traffic with read-data and SRAM-write scoreboards
module tb_ahb_sync_sram_bridge;
  logic clk = 0, rst_n = 0, hready = 1, hwrite = 0;
  logic [1:0] htrans = 0;
  logic [2:0] hsize = 0;
  logic [31:0] haddr = 0, hwdata = 0, hrdata, sram_wdata, sram_rdata = 0;
  logic hready_resp, hresp, sram_cs_n, sram_we_n;
  logic [3:0] sram_be_n;
  logic [10:0] sram_addr;
  ahb_sync_sram_bridge dut (
    .clk(clk), .rst_n(rst_n), .ahbls_hready(hready), .ahbls_hready_resp(hready_resp),
    .ahbls_hresp(hresp), .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans),
    .ahbls_hsize(hsize), .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata), .sram_cs_n(sram_cs_n),
    .sram_we_n(sram_we_n), .sram_be_n(sram_be_n), .sram_addr(sram_addr),
    .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
  );
  always #5 clk = ~clk;
  typedef struct {logic [10:0] a; logic [3:0] be; logic [31:0] d;} wr_t;
  wr_t wq[$];
  logic [31:0] rq[$];
  int total = 0, bad = 0;
  // SRAM model with a few preloaded words
  bit [31:0] mem [0:2047];
  bit loaded = 0;
  always @(posedge clk) begin
    if (!loaded) begin
      mem[9] <= 32'hCAFEF00D;
      mem[16] <= 32'h0BADF00D;
      mem[17] <= 32'h17171717;
      loaded <= 1;
    end else if (!sram_cs_n) begin
      if (!sram_we_n) begin
        for (int i = 0; i < 4; i++)
          if (!sram_be_n[i]) mem[sram_addr][8*i +: 8] <= sram_wdata[8*i +: 8];
      end else sram_rdata <= mem[sram_addr];
    end
  end
  logic rd_dph = 0;
  always @(posedge clk) rd_dph <= rst_n && hready && htrans[1] && !hwrite;
  always @(negedge clk) begin
    logic [31:0] e;
    wr_t w;
    total++;
    if (hready_resp !== 1'b1 || hresp !== 1'b0) begin
      bad++;
      $display("FAIL resp hready_resp=%b hresp=%b required 1/0", hready_resp, hresp);
    end
    total++;
    if (dut.capture === 1'b1 && dut.wbuf_valid === 1'b1) begin
      bad++;
      $display("FAIL overflow capture while buffer valid at %0t", $time);
    end
    if (rd_dph) begin
      total++;
      if (rq.size() == 0) begin
        bad++;
        $display("FAIL rdata unexpected read data phase got=%h", hrdata);
      end else begin
        e = rq.pop_front();
        if (hrdata !== e) begin
          bad++;
          $display("FAIL rdata got=%h required=%h", hrdata, e);
        end
      end
    end
    if (sram_cs_n === 1'b0 && sram_we_n === 1'b0) begin
      total++;
      if (wq.size() == 0) begin
        bad++;
        $display("FAIL sram_wr unexpected write addr=%h be_n=%b data=%h", sram_addr, sram_be_n, sram_wdata);
      end else begin
        w = wq.pop_front();
        if (sram_addr !== w.a || sram_be_n !== w.be || sram_wdata !== w.d) begin
          bad++;
          $display("FAIL sram_wr got addr=%h be_n=%b data=%h required addr=%h be_n=%b data=%h",
                   sram_addr, sram_be_n, sram_wdata, w.a, w.be, w.d);
        end
      end
    end
  end
  logic [31:0] pend = 0;
  task automatic bus(input logic [1:0] tr, input logic w, input logic [31:0] a,
                     input logic [2:0] sz, input logic [31:0] d);
    hwdata = pend;
    htrans = tr;
    hwrite = w;
    haddr = a;
    hsize = sz;
    pend = d;
    @(posedge clk);
    #1;
  endtask
  task automatic wr(input logic [31:0] a, input logic [2:0] sz, input logic [31:0] d,
                    input logic expect_wr, input logic [3:0] be);
    if (expect_wr) wq.push_back('{a[12:2], be, d});
    bus(2'b10, 1'b1, a, sz, d);
  endtask
  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    rq.push_back(e);
    bus(2'b10, 1'b0, a, 3'd2, 32'h0);
  endtask
  task automatic idle();
    bus(2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
  endtask
  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h required=%h", n, act, exp);
    end
  endtask
  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_cs_n", {31'b0, sram_cs_n}, 1);
    chk("reset_we_n", {31'b0, sram_we_n}, 1);
    chk("reset_be_n", {28'b0, sram_be_n}, 32'hF);
    chk("reset_wbuf", {31'b0, dut.wbuf_valid}, 0);
    rst_n = 1;
    // 1: word write then read back
    wr(32'h10, 3'd2, 32'hDEADBEEF, 1, 4'b0000);
    idle();
    rd(32'h10, 32'hDEADBEEF);
    idle();
    // 2: byte write merged into an immediately following read
    wr(32'h10, 3'd2, 32'h11223344, 1, 4'b0000);
    idle();
    wr(32'h13, 3'd0, 32'hA5000000, 1, 4'b0111);
    rd(32'h10, 32'hA5223344);
    chk("t2_wbuf_set", {31'b0, dut.wbuf_valid}, 1);
    idle();
    chk("t2_wbuf_clr", {31'b0, dut.wbuf_valid}, 0);
    // 3: buffer held across two reads, merge from the buffer
    wr(32'h20, 3'd2, 32'h12345678, 1, 4'b0000);
    rd(32'h24, 32'hCAFEF00D);
    rd(32'h20, 32'h12345678);
    chk("t3_wbuf_held", {31'b0, dut.wbuf_valid}, 1);
    idle();
    chk("t3_wbuf_clr", {31'b0, dut.wbuf_valid}, 0);
    rd(32'h20, 32'h12345678);
    idle();
    // 4: back-to-back direct writes
    wr(32'h0, 3'd2, 32'h01010101, 1, 4'b0000);
    chk("t4_wbuf0", {31'b0, dut.wbuf_valid}, 0);
    wr(32'h4, 3'd2, 32'h02020202, 1, 4'b0000);
    chk("t4_wbuf1", {31'b0, dut.wbuf_valid}, 0);
    wr(32'h8, 3'd2, 32'h03030303, 1, 4'b0000);
    chk("t4_wbuf2", {31'b0, dut.wbuf_valid}, 0);
    idle();
    chk("t4_wbuf3", {31'b0, dut.wbuf_valid}, 0);
    // 5: reset discards a buffered write
    wr(32'h40, 3'd2, 32'h55555555, 0, 4'b0000);
    rd(32'h44, 32'h17171717);
    chk("t5_wbuf_set", {31'b0, dut.wbuf_valid}, 1);
    rst_n = 0;
    idle();
    rst_n = 1;
    chk("t5_wbuf_clr", {31'b0, dut.wbuf_valid}, 0);
    chk("t5_cs_n", {31'b0, sram_cs_n}, 1);
    rd(32'h40, 32'h0BADF00D);
    idle();
    // 6: halfword write to the upper lanes, then read merged word
    wr(32'h2, 3'd1, 32'hBEEF0000, 1, 4'b0011);
    idle();
    rd(32'h0, 32'hBEEF0101);
    // aliasing of upper address bits onto word 4
    rd(32'h2010, 32'hA5223344);
    repeat (3) idle();
    chk("wr_queue_empty", wq.size(), 0);
    chk("rd_queue_empty", rq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
  initial begin
    #100000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end
endmodule
